// File: rtl/thermal_pkg.sv
// rtl/thermal_pkg.sv - shared types, pixel width and saturation helper for the thermal path
package thermal_pkg;

   // Pixel width shared with data_normalizer
   localparam int PIX_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FINISH  = 2'd2
   } t_tracker_states;

   // Clamp a signed value into the two's complement range of a w-bit word (w <= 31)
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)
         sat_signed = hi;
      else if (v < lo)
         sat_signed = lo;
      else
         sat_signed = v;
   endfunction

endpackage

// File: rtl/minmax_tracker.sv
// rtl/minmax_tracker.sv - signed per-frame min/max registers and range compute; FRAME_RANGE_TRACKER_MIN_RANGE_EN widens flat-scene windows
import thermal_pkg::*;

module minmax_tracker #(
   parameter int DATAW     = PIX_W,
   parameter int MIN_RANGE = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_update,
   input  logic [DATAW-1:0] i_data,
   output logic [DATAW-1:0] o_min,
   output logic [DATAW-1:0] o_range
);

   logic signed [DATAW-1:0] min_q;
   logic signed [DATAW-1:0] max_q;
   logic signed [DATAW:0]   diff;
   logic signed [31:0]      diff32;
   logic signed [31:0]      range_sat32;
   logic [DATAW-1:0]        range_nz;
   logic                    sat_unused;

   // Load both trackers on the first pixel, otherwise widen toward each new pixel
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         min_q <= '0;
         max_q <= '0;
      end else if (i_load) begin
         min_q <= $signed(i_data);
         max_q <= $signed(i_data);
      end else if (i_update) begin
         if ($signed(i_data) < min_q)
            min_q <= $signed(i_data);
         if ($signed(i_data) > max_q)
            max_q <= $signed(i_data);
      end
   end

`ifdef FRAME_RANGE_TRACKER_MIN_RANGE_EN
   logic signed [31:0] min_adj32;

   // Range one bit wider than a pixel, clamped, never zero; narrow windows are widened and recentred
   always_comb begin
      diff        = {max_q[DATAW-1], max_q} - {min_q[DATAW-1], min_q};
      diff32      = 32'(diff);
      range_sat32 = sat_signed(diff32, DATAW);
      range_nz    = (range_sat32 == 32'sd0) ? DATAW'(1) : range_sat32[DATAW-1:0];
      min_adj32   = 32'(min_q);
      o_min       = min_q;
      o_range     = range_nz;
      if (diff32 < 32'(MIN_RANGE)) begin
         min_adj32 = sat_signed(32'(min_q) - ((32'(MIN_RANGE) - diff32) >>> 1), DATAW);
         o_min     = min_adj32[DATAW-1:0];
         o_range   = DATAW'(MIN_RANGE);
      end
   end

   assign sat_unused = ^{range_sat32[31:DATAW], min_adj32[31:DATAW]};
`else
   localparam int MIN_RANGE_UNUSED = MIN_RANGE;

   // Range one bit wider than a pixel, clamped to the positive maximum, never zero
   always_comb begin
      diff        = {max_q[DATAW-1], max_q} - {min_q[DATAW-1], min_q};
      diff32      = 32'(diff);
      range_sat32 = sat_signed(diff32, DATAW);
      range_nz    = (range_sat32 == 32'sd0) ? DATAW'(1) : range_sat32[DATAW-1:0];
      o_min       = min_q;
      o_range     = range_nz;
   end

   assign sat_unused = ^range_sat32[31:DATAW];
`endif

endmodule

// File: rtl/frame_range_tracker.sv
// rtl/frame_range_tracker.sv - frame buffer writer with per-frame min/range and normalizer start; option FRAME_RANGE_TRACKER_MIN_RANGE_EN
import thermal_pkg::*;

module frame_range_tracker #(
   parameter int  DATAW     = PIX_W,
   parameter int  MAX_ADDR  = 768,
   parameter int  MIN_RANGE = 16,
   localparam int ADDRW     = $clog2(MAX_ADDR)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic             i_sof,
   input  logic [DATAW-1:0] i_data,
   input  logic             i_norm_busy,
   output logic             o_wr_valid,
   output logic [ADDRW-1:0] o_wr_addr,
   output logic [DATAW-1:0] o_wr_data,
   output logic [DATAW-1:0] o_min,
   output logic [DATAW-1:0] o_range,
   output logic             o_start,
   output logic             o_dropped
);

   t_tracker_states  state_q;
   logic [ADDRW-1:0] addr_q;
   logic [ADDRW-1:0] addr_d;
   logic             sof_hit;
   logic             accept_d;
   logic             drop_d;
   logic             load_d;
   logic             update_d;
   logic             last_d;
   logic             drop_pend_q;
   logic             wr_valid_q;
   logic [ADDRW-1:0] wr_addr_q;
   logic [DATAW-1:0] wr_data_q;
   logic [DATAW-1:0] min_q;
   logic [DATAW-1:0] range_q;
   logic             start_q;
   logic             dropped_q;
   logic [DATAW-1:0] res_min;
   logic [DATAW-1:0] res_range;

   // Decide whether this cycle's pixel is written, starts a frame or drops one
   always_comb begin
      sof_hit  = i_valid & i_sof;
      accept_d = 1'b0;
      drop_d   = 1'b0;
      addr_d   = addr_q;
      if (sof_hit) begin
         addr_d = '0;
         if (i_norm_busy)
            drop_d = 1'b1;
         else
            accept_d = 1'b1;
      end else if (i_valid && state_q == CAPTURE) begin
         accept_d = 1'b1;
      end
      load_d   = accept_d & sof_hit;
      update_d = accept_d & ~sof_hit;
      last_d   = (addr_d == ADDRW'(MAX_ADDR - 1));
   end

   minmax_tracker #(
      .DATAW     (DATAW),
      .MIN_RANGE (MIN_RANGE)
   ) u_minmax (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (load_d),
      .i_update (update_d),
      .i_data   (i_data),
      .o_min    (res_min),
      .o_range  (res_range)
   );

   // Frame FSM with registered write port, results and status pulses.
   // A drop decided in FINISH is deferred a cycle so it never coincides with o_start.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         drop_pend_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         min_q       <= '0;
         range_q     <= '0;
         start_q     <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         wr_valid_q <= accept_d;
         if (accept_d) begin
            wr_addr_q <= addr_d;
            wr_data_q <= i_data;
         end

         start_q     <= (state_q == FINISH);
         drop_pend_q <= drop_d & (state_q == FINISH);
         dropped_q   <= (drop_d & (state_q != FINISH)) | drop_pend_q;
         if (state_q == FINISH) begin
            min_q   <= res_min;
            range_q <= res_range;
         end

         if (accept_d) begin
            state_q <= last_d ? FINISH : CAPTURE;
            addr_q  <= last_d ? '0 : addr_d + ADDRW'(1);
         end else if (drop_d) begin
            state_q <= IDLE;
            addr_q  <= '0;
         end else if (state_q == FINISH) begin
            state_q <= IDLE;
         end
      end
   end

   assign o_wr_valid = wr_valid_q;
   assign o_wr_addr  = wr_addr_q;
   assign o_wr_data  = wr_data_q;
   assign o_min      = min_q;
   assign o_range    = range_q;
   assign o_start    = start_q;
   assign o_dropped  = dropped_q;

endmodule

// File: tb/tb_frame_range_tracker.sv
// tb/tb_frame_range_tracker.sv - directed self-checking bench for frame_range_tracker
module tb_frame_range_tracker;

   localparam int DATAW    = 16;
   localparam int MAX_ADDR = 20;
   localparam int ADDRW    = $clog2(MAX_ADDR);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid;
   logic             sof;
   logic [DATAW-1:0] data;
   logic             busy;
   logic             wr_valid;
   logic [ADDRW-1:0] wr_addr;
   logic [DATAW-1:0] wr_data;
   logic [DATAW-1:0] min_o;
   logic [DATAW-1:0] range_o;
   logic             start;
   logic             dropped;

   int checks = 0;
   int errors = 0;

   int wr_cnt = 0;
   int start_cnt = 0;
   int drop_cnt = 0;
   int both_cnt = 0;
   int wr_a [0:255];
   int wr_d [0:255];

   int base_wr, base_st, base_dr;

   frame_range_tracker #(
      .DATAW     (DATAW),
      .MAX_ADDR  (MAX_ADDR),
      .MIN_RANGE (16)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .i_sof       (sof),
      .i_data      (data),
      .i_norm_busy (busy),
      .o_wr_valid  (wr_valid),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_min       (min_o),
      .o_range     (range_o),
      .o_start     (start),
      .o_dropped   (dropped)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid) begin
         if (wr_cnt < 256) begin
            wr_a[wr_cnt] = int'(wr_addr);
            wr_d[wr_cnt] = int'($signed(wr_data));
         end
         wr_cnt++;
      end
      if (start)
         start_cnt++;
      if (dropped)
         drop_cnt++;
      if (start && dropped)
         both_cnt++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input int d);
      valid = v;
      sof   = s;
      data  = DATAW'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 0);
   endtask

   task automatic snap();
      base_wr = wr_cnt;
      base_st = start_cnt;
      base_dr = drop_cnt;
   endtask

   task automatic check_seq(input string tag, input int base, input int n, input int d0, input int dstep);
      for (int k = 0; k < n; k++) begin
         check({tag, "_addr"}, wr_a[base + k], k);
         check({tag, "_data"}, wr_d[base + k], d0 + k * dstep);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_valid"}, int'(wr_valid), 0);
      check({tag, "_wr_addr"}, int'(wr_addr), 0);
      check({tag, "_wr_data"}, int'(wr_data), 0);
      check({tag, "_min"}, int'(min_o), 0);
      check({tag, "_range"}, int'(range_o), 0);
      check({tag, "_start"}, int'(start), 0);
      check({tag, "_dropped"}, int'(dropped), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      sof   = 1'b0;
      data  = '0;
      busy  = 1'b0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // 1: ramp 0..19
      snap();
      for (int i = 0; i < MAX_ADDR; i++)
         step(1'b1, i == 0, i);
      check("t1_last_wr_valid", int'(wr_valid), 1);
      check("t1_last_wr_addr", int'(wr_addr), 19);
      check("t1_start_early", int'(start), 0);
      idle(1);
      check("t1_start_pulse", int'(start), 1);
      check("t1_min", int'($signed(min_o)), 0);
      check("t1_range", int'($signed(range_o)), 19);
      idle(1);
      check("t1_start_end", int'(start), 0);
      idle(2);
      check("t1_wr_count", wr_cnt - base_wr, 20);
      check_seq("t1", base_wr, 20, 0, 1);
      check("t1_start_count", start_cnt - base_st, 1);

      // 2: -5..14 with three gaps
      snap();
      for (int i = 0; i < MAX_ADDR; i++) begin
         step(1'b1, i == 0, i - 5);
         if (i == 3 || i == 8 || i == 15)
            idle(1 + (i % 2));
      end
      idle(3);
      check("t2_wr_count", wr_cnt - base_wr, 20);
      check_seq("t2", base_wr, 20, -5, 1);
      check("t2_min", int'($signed(min_o)), -5);
      check("t2_range", int'($signed(range_o)), 19);
      check("t2_start_count", start_cnt - base_st, 1);

      // 3: flat frame of 7
      snap();
      for (int i = 0; i < MAX_ADDR; i++)
         step(1'b1, i == 0, 7);
      idle(3);
      check("t3_wr_count", wr_cnt - base_wr, 20);
      check_seq("t3", base_wr, 20, 7, 0);
`ifdef FRAME_RANGE_TRACKER_MIN_RANGE_EN
      check("t3_min", int'($signed(min_o)), -1);
      check("t3_range", int'($signed(range_o)), 16);
`else
      check("t3_min", int'($signed(min_o)), 7);
      check("t3_range", int'($signed(range_o)), 1);
`endif
      check("t3_start_count", start_cnt - base_st, 1);

      // 4: alternating extremes, range saturates
      snap();
      for (int i = 0; i < MAX_ADDR; i++)
         step(1'b1, i == 0, (i % 2 == 0) ? -32768 : 32767);
      idle(3);
      check("t4_wr_count", wr_cnt - base_wr, 20);
      check("t4_min", int'($signed(min_o)), -32768);
      check("t4_range", int'($signed(range_o)), 32767);
      check("t4_start_count", start_cnt - base_st, 1);

      // 5: busy at sof drops the frame, next frame captures
      snap();
      busy = 1'b1;
      step(1'b1, 1'b1, 55);
      check("t5_dropped_pulse", int'(dropped), 1);
      check("t5_no_write", int'(wr_valid), 0);
      busy = 1'b0;
      for (int i = 1; i < MAX_ADDR; i++)
         step(1'b1, 1'b0, 55 + i);
      check("t5_dropped_end", int'(dropped), 0);
      idle(3);
      check("t5_drop_wr_count", wr_cnt - base_wr, 0);
      check("t5_drop_start_count", start_cnt - base_st, 0);
      check("t5_drop_count", drop_cnt - base_dr, 1);
      check("t5_min_hold", int'($signed(min_o)), -32768);
      check("t5_range_hold", int'($signed(range_o)), 32767);
      snap();
      for (int i = 0; i < MAX_ADDR; i++)
         step(1'b1, i == 0, 100 + i);
      idle(3);
      check("t5_wr_count", wr_cnt - base_wr, 20);
      check_seq("t5", base_wr, 20, 100, 1);
      check("t5_min", int'($signed(min_o)), 100);
      check("t5_range", int'($signed(range_o)), 19);
      check("t5_start_count", start_cnt - base_st, 1);

      // 6a: restart at pixel 10 of a frame
      snap();
      for (int i = 0; i < 10; i++)
         step(1'b1, i == 0, 50 + i);
      for (int i = 0; i < MAX_ADDR; i++)
         step(1'b1, i == 0, 200 - 3 * i);
      idle(3);
      check("t6_wr_count", wr_cnt - base_wr, 30);
      check_seq("t6", base_wr + 10, 20, 200, -3);
      check("t6_min", int'($signed(min_o)), 143);
      check("t6_range", int'($signed(range_o)), 57);
      check("t6_start_count", start_cnt - base_st, 1);

      // 6b: reset at pixel 12 abandons the frame
      snap();
      for (int i = 0; i < 12; i++)
         step(1'b1, i == 0, 300 + i);
      rst_n = 1'b0;
      step(1'b0, 1'b0, 0);
      check_all_zero("t6_rst");
      rst_n = 1'b1;
      for (int i = 12; i < MAX_ADDR; i++)
         step(1'b1, 1'b0, 300 + i);
      idle(4);
      check("t6_rst_start_count", start_cnt - base_st, 0);
      check("t6_rst_wr_count", wr_cnt - base_wr, 12);
      check_all_zero("t6_after");

      check("start_dropped_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_range_tracker.md
Name: frame_range_tracker

Overview:
- Front end of the normalization path: accepts the raw signed pixel stream from the sensor reader and writes each pixel into the frame buffer that data_normalizer later reads.
- Tracks the per-frame minimum and maximum and computes range = max - min.
- At end of frame, presents min/range and pulses start to data_normalizer. It is the writer for the buffer that the normalizer reads.

Parameters:
- DATAW, 16, raw pixel width (signed two's complement).
- MAX_ADDR, 768, pixels per frame; ADDRW = $clog2(MAX_ADDR).
- MIN_RANGE, 16, range floor (used only with the optional feature).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  raw pixel valid.
- i_sof  in  1  start of frame; qualified by i_valid; marks pixel 0.
- i_data  in  DATAW  signed raw pixel.
- i_norm_busy  in  1  normalizer still processing the previous frame.
- o_wr_valid  out  1  buffer write strobe.
- o_wr_addr  out  ADDRW  buffer write address.
- o_wr_data  out  DATAW  raw pixel to buffer.
- o_min  out  DATAW  signed frame minimum.
- o_range  out  DATAW  signed frame range (max - min).
- o_start  out  1  one-cycle pulse: min/range valid, buffer complete.
- o_dropped  out  1  one-cycle pulse: frame discarded because the normalizer was busy.

Behaviour:
- Reset (i_rst_n=0 sampled at posedge): all outputs 0, state IDLE, addr 0, min/max trackers cleared. Reset mid-frame abandons the frame and raises no o_start.
- States:
  - IDLE: waits for i_valid&i_sof. If i_norm_busy=0, go to CAPTURE and accept the pixel as addr 0. If i_norm_busy=1, pulse o_dropped the next cycle and stay in IDLE, ignoring pixels until the next sof.
  - CAPTURE: each i_valid pixel written at addr, then addr++. When the pixel at addr MAX_ADDR-1 is accepted, go to FINISH.
  - FINISH: one cycle; compute range and register o_min/o_range; go to IDLE with o_start=1 for exactly that transition cycle.
- Write latency: o_wr_valid/addr/data registered, 1 cycle after the accepted pixel. o_wr_valid never high in IDLE for rejected pixels.
- First pixel (sof) loads both min and max directly. Later pixels: min=min(min,d), max=max(max,d), signed compare.
- Range arithmetic:
  - Computed in DATAW+1 bits. If the result exceeds 2^(DATAW-1)-1, saturate to 2^(DATAW-1)-1.
  - Range 0 (flat frame) forced to 1 so the downstream divider never sees 0.
- o_min/o_range hold stable from o_start until the next FINISH; they are never updated mid-frame.
- i_sof during CAPTURE: restart. The partial frame is discarded, addr resets to 0, trackers reload from this pixel, and no o_start is issued. i_norm_busy is re-checked at the restart.
- Gaps (i_valid=0) allowed anywhere; addr does not advance.
- i_valid in FINISH: pixel ignored unless it carries sof, in which case it is handled as IDLE would handle it, in the same cycle.
- o_start and o_dropped are never high together.

Optional Feature:
- Macro: FRAME_RANGE_TRACKER_MIN_RANGE_EN.
  - Defined: if the computed range < MIN_RANGE, o_range = MIN_RANGE and o_min = min - ((MIN_RANGE - range)>>1), saturating at -2^(DATAW-1). This centres the window and limits noise gain on flat scenes.
  - Undefined: only the zero-to-1 rule applies; the MIN_RANGE parameter is unused.

Decomposition:
- Shared package thermal_pkg:
  - state enum t_tracker_states {IDLE=0, CAPTURE=1, FINISH=2}.
  - Signed saturation helper function sat_signed.
  - Pixel width constant shared with data_normalizer.
- One natural sub-module, minmax_tracker: load/update inputs, signed min/max registers, and the range compute with saturation. The FSM and write port stay in the top.

Test Plan (MAX_ADDR=20, DATAW=16):
1. Ramp 0..19 with sof on pixel 0, i_norm_busy=0 -> 20 writes at addr 0..19 with data = addr; o_start 1 cycle after the last write; o_min=0, o_range=19.
2. Values -5..14 with 3 random i_valid gaps -> addr monotonic with no skips; o_min=-5, o_range=19; o_start exactly once.
3. Flat frame, all 7 -> o_min=7, o_range=1. With FRAME_RANGE_TRACKER_MIN_RANGE_EN and MIN_RANGE=16 -> o_min=-1, o_range=16.
4. Alternating -32768/32767 -> o_range saturates to 32767; o_min=-32768.
5. sof with i_norm_busy=1 -> o_dropped pulse, no o_wr_valid for that frame. The next sof with busy=0 captures normally.
6. sof again at pixel 10, then a full frame; separately, i_rst_n=0 at pixel 12 -> only one o_start (second frame) after restart; none after reset; all outputs 0 after reset.
